// File: rtl/zxuno_multiboot_pkg.sv
// rtl/zxuno_multiboot_pkg.sv - register numbers, golden address, ICAP IPROG words and helpers
// Build option: define QUAD_SPI_READ_EN to make the reboot use quad-output fast read (6Bh).
package zxuno_multiboot_pkg;

    localparam logic [7:0]  ADDR_COREADDR = 8'hFC;
    localparam logic [7:0]  ADDR_COREBOOT = 8'hFD;
    localparam logic [23:0] GOLDEN_CORE   = 24'h0B0000;

    // IPROG sequence words, in Spartan-6 configuration packet format
    localparam logic [15:0] IPROG_DUMMY   = 16'hFFFF;
    localparam logic [15:0] IPROG_SYNC1   = 16'hAA99;
    localparam logic [15:0] IPROG_SYNC2   = 16'h5566;
    localparam logic [15:0] IPROG_GEN1    = 16'h3261;
    localparam logic [15:0] IPROG_GEN2    = 16'h3281;
    localparam logic [15:0] IPROG_CMDHDR  = 16'h30A1;
    localparam logic [15:0] IPROG_CMD     = 16'h000E;
    localparam logic [15:0] IPROG_NOOP    = 16'h2000;
    localparam logic [15:0] IPROG_PAD     = 16'h1111;

    localparam logic [7:0]  RDOP_1X       = 8'h03;
    localparam logic [7:0]  RDOP_QUAD     = 8'h6B;

`ifdef QUAD_SPI_READ_EN
    localparam logic [7:0]  RDOP          = RDOP_QUAD;
`else
    localparam logic [7:0]  RDOP          = RDOP_1X;
`endif

    // ICAP on Spartan-6 expects each byte bit-swapped relative to the bitstream
    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/zxuno_multiboot_seq.sv
// rtl/zxuno_multiboot_seq.sv - ICAP IPROG sequencer with command table and byte bit-reversal
// Ports: icap_clk (sequencer clock), boot_core (start request), spi_addr (reboot address),
//        icap_ce_n / icap_we_n / icap_i (ICAP inputs, registered).
module zxuno_multiboot_seq
    import zxuno_multiboot_pkg::*;
(
    input  logic        icap_clk,
    input  logic        boot_core,
    input  logic [23:0] spi_addr,
    output logic        icap_ce_n,
    output logic        icap_we_n,
    output logic [15:0] icap_i
);

    // idx[4] marks "running"; idx[3:0] selects the command word
    logic [4:0]  idx    = 5'd0;
    logic        ce_n_q = 1'b1;
    logic        we_n_q = 1'b1;
    logic [15:0] word_q = IPROG_DUMMY;

    // Address-dependent table entries, refreshed every icap_clk cycle
    logic [15:0] gen1_q = 16'h0000;
    logic [15:0] gen2_q = 16'h0000;

    logic [17:0] cmd;   // {ce_n, we_n, word}

    always_comb begin
        cmd = {2'b00, IPROG_PAD};
        case (idx[3:0])
            4'd0:  cmd = {2'b11, IPROG_DUMMY};
            4'd1:  cmd = {2'b00, IPROG_SYNC1};
            4'd2:  cmd = {2'b00, IPROG_SYNC2};
            4'd3:  cmd = {2'b00, IPROG_GEN1};
            4'd4:  cmd = {2'b00, gen1_q};
            4'd5:  cmd = {2'b00, IPROG_GEN2};
            4'd6:  cmd = {2'b00, gen2_q};
            4'd7:  cmd = {2'b00, IPROG_CMDHDR};
            4'd8:  cmd = {2'b00, IPROG_CMD};
            4'd9, 4'd10, 4'd11, 4'd12, 4'd13:
                   cmd = {2'b00, IPROG_NOOP};
            default: cmd = {2'b00, IPROG_PAD};
        endcase
    end

    always_ff @(posedge icap_clk) begin
        gen1_q <= spi_addr[15:0];
        gen2_q <= {RDOP, spi_addr[23:16]};
        if (boot_core && !idx[4]) begin
            idx <= 5'd16;
        end else begin
            {ce_n_q, we_n_q, word_q} <= cmd;
            // Counts only while running; wraps from 31 to 0 and parks there
            idx <= idx + {4'b0000, idx[4]};
        end
    end

    assign icap_ce_n = ce_n_q;
    assign icap_we_n = we_n_q;
    assign icap_i    = {bitrev8(word_q[15:8]), bitrev8(word_q[7:0])};

endmodule

// File: rtl/zxuno_multiboot_ctrl.sv
// rtl/zxuno_multiboot_ctrl.sv - ZX-UNO register slave holding a flash address and rebooting via ICAP
// Ports: clk, rst_n (sync, active-low); register bus zxuno_addr, regaddr_changed, zxuno_regrd,
//        zxuno_regwr, din, dout, oe; ICAP side icap_clk (clk/2, to BUFG), icap_ce_n, icap_we_n, icap_i.
// Build option: QUAD_SPI_READ_EN selects the quad-output read opcode in the IPROG sequence.
module zxuno_multiboot_ctrl
    import zxuno_multiboot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  zxuno_addr,
    input  logic        regaddr_changed,
    input  logic        zxuno_regrd,
    input  logic        zxuno_regwr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        oe,
    output logic        icap_clk,
    output logic        icap_ce_n,
    output logic        icap_we_n,
    output logic [15:0] icap_i
);

    logic        sel_addr;
    logic        sel_boot;
    logic        rst;

    // Address and readback latch survive resets so a reboot target is never lost
    logic [23:0] spi_addr   = GOLDEN_CORE;
    logic [7:0]  addrout    = 8'h00;
    logic        icap_clk_q = 1'b0;

    logic        wr_flag;
    logic        rd_flag;
    logic        boot_flag;
    logic        boot_core;
    logic [1:0]  chunk;

    assign sel_addr = (zxuno_addr == ADDR_COREADDR);
    assign sel_boot = (zxuno_addr == ADDR_COREBOOT);

    // Re-selecting the address port restarts the byte pointer for a fresh 3-byte access
    assign rst = !rst_n || (regaddr_changed && sel_addr);

    assign oe   = sel_addr && zxuno_regrd;
    assign dout = addrout;

    always_ff @(posedge clk) begin
        icap_clk_q <= ~icap_clk_q;
    end

    assign icap_clk = icap_clk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_flag   <= 1'b0;
            rd_flag   <= 1'b0;
            boot_flag <= 1'b0;
            boot_core <= 1'b0;
            chunk     <= 2'd0;
        end else begin
            // Flags turn level strobes into single actions per bus cycle
            wr_flag <= sel_addr && zxuno_regwr;
            if (sel_addr && zxuno_regwr && !wr_flag) begin
                spi_addr <= {spi_addr[15:0], din};
            end

            rd_flag <= sel_addr && zxuno_regrd;
            if (sel_addr && zxuno_regrd && !rd_flag) begin
                case (chunk)
                    2'd0:    addrout <= spi_addr[23:16];
                    2'd1:    addrout <= spi_addr[15:8];
                    default: addrout <= spi_addr[7:0];
                endcase
                chunk <= (chunk == 2'd2) ? 2'd0 : chunk + 2'd1;
            end

            if (sel_boot) begin
                boot_flag <= zxuno_regwr;
                if (zxuno_regwr && !boot_flag && din[0]) begin
                    boot_core <= 1'b1;
                end
            end else begin
                boot_flag <= 1'b0;
                boot_core <= 1'b0;
            end
        end
    end

    zxuno_multiboot_seq u_seq (
        .icap_clk  (icap_clk_q),
        .boot_core (boot_core),
        .spi_addr  (spi_addr),
        .icap_ce_n (icap_ce_n),
        .icap_we_n (icap_we_n),
        .icap_i    (icap_i)
    );

endmodule

// File: tb/tb_zxuno_multiboot_ctrl.sv
// tb/tb_zxuno_multiboot_ctrl.sv - directed self-checking bench for zxuno_multiboot_ctrl
module tb_zxuno_multiboot_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  zxuno_addr;
    logic        regaddr_changed;
    logic        zxuno_regrd;
    logic        zxuno_regwr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        oe;
    logic        icap_clk;
    logic        icap_ce_n;
    logic        icap_we_n;
    logic [15:0] icap_i;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_words [0:14];

    zxuno_multiboot_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .zxuno_addr      (zxuno_addr),
        .regaddr_changed (regaddr_changed),
        .zxuno_regrd     (zxuno_regrd),
        .zxuno_regwr     (zxuno_regwr),
        .din             (din),
        .dout            (dout),
        .oe              (oe),
        .icap_clk        (icap_clk),
        .icap_ce_n       (icap_ce_n),
        .icap_we_n       (icap_we_n),
        .icap_i          (icap_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        zxuno_addr  = addr;
        din         = data;
        zxuno_regwr = 1'b1;
        @(negedge clk);
        zxuno_regwr = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_chk(input logic [7:0] exp, input string tag);
        @(negedge clk);
        zxuno_addr  = 8'hFC;
        zxuno_regrd = 1'b1;
        #1;
        check({tag, "_oe"}, {31'd0, oe}, 32'd1);
        @(negedge clk);
        zxuno_regrd = 1'b0;
        check(tag, {24'd0, dout}, {24'd0, exp});
        @(negedge clk);
    endtask

    task automatic reselect_fc();
        @(negedge clk);
        zxuno_addr      = 8'hFC;
        regaddr_changed = 1'b1;
        @(negedge clk);
        regaddr_changed = 1'b0;
    endtask

    task automatic collect_stream();
        bit found = 0;
        int cnt_run = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge icap_clk); #1;
            if (icap_ce_n == 1'b0) found = 1;
        end
        check("seq_start", {31'd0, found}, 32'd1);
        if (found) begin
            for (int k = 0; k < 15; k++) begin
                if (k > 0) begin
                    @(posedge icap_clk); #1;
                end
                check($sformatf("word%0d", k + 1), {16'd0, icap_i}, {16'd0, exp_words[k]});
                check($sformatf("cewe%0d", k + 1), {30'd0, icap_ce_n, icap_we_n}, 32'd0);
            end
            @(posedge icap_clk); #1;
            check("end_word", {16'd0, icap_i}, 32'h0000FFFF);
            check("end_cewe", {30'd0, icap_ce_n, icap_we_n}, 32'd3);
            for (int i = 0; i < 20; i++) begin
                @(posedge icap_clk); #1;
                if (icap_ce_n == 1'b0) cnt_run++;
            end
            check("no_restart", cnt_run, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt_run;

        exp_words[0]  = 16'h5599;
        exp_words[1]  = 16'hAA66;
        exp_words[2]  = 16'h4C86;
        exp_words[3]  = 16'h2C6A;
        exp_words[4]  = 16'h4C81;
`ifdef QUAD_SPI_READ_EN
        exp_words[5]  = 16'hD648;
`else
        exp_words[5]  = 16'hC048;
`endif
        exp_words[6]  = 16'h0C85;
        exp_words[7]  = 16'h0070;
        for (int i = 8; i < 13; i++) exp_words[i] = 16'h0400;
        exp_words[13] = 16'h8888;
        exp_words[14] = 16'h8888;

        rst_n           = 1'b0;
        zxuno_addr      = 8'h00;
        regaddr_changed = 1'b0;
        zxuno_regrd     = 1'b0;
        zxuno_regwr     = 1'b0;
        din             = 8'h00;

        #1;
        check("dout_powerup", {24'd0, dout}, 32'd0);
        check("oe_reset", {31'd0, oe}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_word", {16'd0, icap_i}, 32'h0000FFFF);
        check("idle_cewe", {30'd0, icap_ce_n, icap_we_n}, 32'd3);

        // Golden address 0B0000, MSB first
        read_chk(8'h0B, "rd_golden0");
        read_chk(8'h00, "rd_golden1");
        read_chk(8'h00, "rd_golden2");

        @(negedge clk);
        zxuno_addr = 8'hFC;
        #1;
        check("oe_noread", {31'd0, oe}, 32'd0);
        zxuno_addr  = 8'hFD;
        zxuno_regrd = 1'b1;
        #1;
        check("oe_otherreg", {31'd0, oe}, 32'd0);
        zxuno_regrd = 1'b0;

        bus_write(8'hFC, 8'h12);
        bus_write(8'hFC, 8'h34);
        bus_write(8'hFC, 8'h56);
        reselect_fc();
        read_chk(8'h12, "rd_addr0");
        read_chk(8'h34, "rd_addr1");
        read_chk(8'h56, "rd_addr2");
        read_chk(8'h12, "rd_wrap");

        // Long write strobe must shift only once: 123456 -> 3456AB
        @(negedge clk);
        zxuno_addr  = 8'hFC;
        din         = 8'hAB;
        zxuno_regwr = 1'b1;
        repeat (5) @(negedge clk);
        zxuno_regwr = 1'b0;
        reselect_fc();
        read_chk(8'h34, "rd_hold0");
        read_chk(8'h56, "rd_hold1");
        read_chk(8'hAB, "rd_hold2");

        bus_write(8'hFC, 8'h12);
        bus_write(8'hFC, 8'h34);
        bus_write(8'hFC, 8'h56);

        // Boot write with din[0]=0 must not start the sequence
        cnt_run = 0;
        fork
            begin
                bus_write(8'hFD, 8'h00);
                repeat (3) @(negedge clk);
                zxuno_addr = 8'h00;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge icap_clk); #1;
                    if (icap_ce_n == 1'b0) cnt_run++;
                end
            end
        join
        check("no_boot_din0", cnt_run, 0);

        fork
            begin
                bus_write(8'hFD, 8'h01);
                repeat (3) @(negedge clk);
                zxuno_addr = 8'h00;
            end
            collect_stream();
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
